capture_ctrl: RTL

// - Sequencer and MCU config block in front of the ADC dual-buffer capture path: generates the ADC sample clock,

---
 rtl/capture_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: ADC capture sequencer and MCU register block.
// Generates the divided ADC sample clock, qualifies comparator edges, issues
// one-cycle capture-start pulses and enforces a holdoff between captures.
// Optional build macro: CAPTURE_CTRL_AUTO_TRIG_EN adds the TIMEOUT register
// and forced triggers after TIMEOUT adc_clk rising edges in WAIT_TRIG.
module capture_ctrl #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 16'h4010,
  parameter logic [DATA_WIDTH-1:0] DIV_RST    = 16'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  addr_en,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  sync_signal_in,
  input  logic                  stable,
  input  logic                  cap_done,
  output logic                  adc_clk,
  output logic                  trig_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OFF_CTRL    = 0;
  localparam logic [DATA_WIDTH-1:0] OFF_DIV     = 1;
  localparam logic [DATA_WIDTH-1:0] OFF_HOLDOFF = 2;
  localparam logic [DATA_WIDTH-1:0] OFF_TIMEOUT = 3;
  localparam logic [DATA_WIDTH-1:0] OFF_STATUS  = 4;
  localparam logic [DATA_WIDTH-1:0] OFF_TRIGCNT = 5;
  localparam logic [DATA_WIDTH-1:0] ONE         = 1;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] addr_reg, ctrl_reg, div_reg, holdoff_reg, trig_cnt_reg;
  logic [DATA_WIDTH-1:0] div_cnt_reg, div_act_reg, hold_cnt_reg;
  logic [DATA_WIDTH-1:0] offset, rd_mux, timeout_rd;
  logic                  bus_wr, bus_rd, wr_ctrl, run_clear_wr;
  logic                  sync_prev_reg, edge_reg;
  logic                  trig_next, busy_next, clr_run, hold_load, force_trig;

  assign bus_wr       = en && rd_en;
  assign bus_rd       = en && wr_en;
  assign offset       = addr_reg - BASE_ADDR;
  assign wr_ctrl      = bus_wr && (offset == OFF_CTRL);
  assign run_clear_wr = wr_ctrl && !rd_data[0];

  // Latch the register address presented on the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                addr_reg <= '0;
    else if (en && addr_en)    addr_reg <= rd_data;
  end

  // Writable configuration registers; a single-shot completion clears run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg    <= '0;
      div_reg     <= DIV_RST;
      holdoff_reg <= '0;
    end else begin
      if (wr_ctrl)                               ctrl_reg    <= rd_data;
      if (bus_wr && offset == OFF_DIV)           div_reg     <= rd_data;
      if (bus_wr && offset == OFF_HOLDOFF)       holdoff_reg <= rd_data;
      if (clr_run)                               ctrl_reg[0] <= 1'b0;
    end
  end

  // Sample clock divider; a new DIV value is picked up only at a toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      div_act_reg <= DIV_RST;
      adc_clk     <= 1'b0;
    end else if (div_cnt_reg == div_act_reg) begin
      div_cnt_reg <= '0;
      div_act_reg <= div_reg;
      adc_clk     <= ~adc_clk;
    end else begin
      div_cnt_reg <= div_cnt_reg + ONE;
    end
  end

  // Registered edge detector, polarity chosen by CTRL[1]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev_reg <= 1'b0;
      edge_reg      <= 1'b0;
    end else begin
      sync_prev_reg <= sync_signal_in;
      edge_reg      <= ctrl_reg[1] ? (sync_prev_reg && !sync_signal_in)
                                   : (!sync_prev_reg && sync_signal_in);
    end
  end

`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
  logic [DATA_WIDTH-1:0] timeout_reg, to_cnt_reg;
  logic                  adc_rise;

  assign adc_rise   = (div_cnt_reg == div_act_reg) && !adc_clk;
  assign timeout_rd = timeout_reg;
  assign force_trig = (timeout_reg != '0) && (to_cnt_reg == timeout_reg);

  // TIMEOUT register write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              timeout_reg <= '0;
    else if (bus_wr && offset == OFF_TIMEOUT) timeout_reg <= rd_data;
  end

  // Count adc_clk rises while waiting; restart outside WAIT_TRIG and on every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   to_cnt_reg <= '0;
    else if (state_reg != WAIT_TRIG || edge_reg)  to_cnt_reg <= '0;
    else if (adc_rise && to_cnt_reg != '1)        to_cnt_reg <= to_cnt_reg + ONE;
  end
`else
  assign timeout_rd = '0;
  assign force_trig = 1'b0;
`endif

  // Sequencer next-state and output decode
  always_comb begin
    state_next = state_reg;
    trig_next  = 1'b0;
    busy_next  = busy;
    clr_run    = 1'b0;
    hold_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ctrl_reg[0]) state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if ((edge_reg && stable) || force_trig) begin
          trig_next  = 1'b1;
          busy_next  = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        // Completion outranks a coincident edge or stable drop
        if (cap_done) begin
          busy_next = 1'b0;
          if (ctrl_reg[2]) begin
            clr_run    = 1'b1;
            state_next = IDLE;
          end else begin
            hold_load  = 1'b1;
            state_next = HOLDOFF;
          end
        end else if (!stable) begin
          busy_next  = 1'b0;
          state_next = WAIT_TRIG;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_reg == '0) state_next = WAIT_TRIG;
      end
      default: state_next = IDLE;
    endcase
    // Stopping via the bus overrides everything, including a same-cycle trigger
    if (run_clear_wr) begin
      state_next = IDLE;
      trig_next  = 1'b0;
      busy_next  = 1'b0;
    end
  end

  // Sequencer state, registered outputs and holdoff counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      trig_out     <= 1'b0;
      busy         <= 1'b0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      trig_out  <= trig_next;
      busy      <= busy_next;
      if (hold_load)                                     hold_cnt_reg <= holdoff_reg;
      else if (state_reg == HOLDOFF && hold_cnt_reg != '0) hold_cnt_reg <= hold_cnt_reg - ONE;
    end
  end

  // Trigger counter: saturating, cleared by any write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                trig_cnt_reg <= '0;
    else if (bus_wr && offset == OFF_TRIGCNT)  trig_cnt_reg <= '0;
    else if (trig_next && trig_cnt_reg != '1)  trig_cnt_reg <= trig_cnt_reg + ONE;
  end

  // Register read multiplexer
  always_comb begin
    rd_mux = '1;
    case (offset)
      OFF_CTRL:    rd_mux = ctrl_reg;
      OFF_DIV:     rd_mux = div_reg;
      OFF_HOLDOFF: rd_mux = holdoff_reg;
      OFF_TIMEOUT: rd_mux = timeout_rd;
      OFF_STATUS:  rd_mux = {{(DATA_WIDTH-4){1'b0}}, stable, busy, state_reg};
      OFF_TRIGCNT: rd_mux = trig_cnt_reg;
      default:     rd_mux = '1;
    endcase
  end

  // Registered read data, valid the cycle after the read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_data <= '1;
    else if (bus_rd) wr_data <= rd_mux;
  end

endmodule
